// File: rtl/sme_host_driver.sv
// sme_host_driver: host-side sequencer for a string/pattern matcher.
// The host fills a 32-entry string buffer and an 8-entry pattern buffer while idle.
// A start request streams the string and the pattern frame, then sends a one-cycle
// terminator and waits for the matcher's verdict.
// The verdict, or a timeout/length error, is held on the result outputs until the
// next transaction completes.
module sme_host_driver #(
    parameter int TIMEOUT = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [5:0] str_len,
    input  logic [3:0] pat_len,
    input  logic       anchor_head,
    input  logic       anchor_tail,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       busy,
    output logic       done,
    output logic       result_match,
    output logic [4:0] result_index,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, GAP, WAIT, FIN} state_t;

    // The last WAIT cycle is chosen so that the WAIT cycles plus the FIN cycle add up
    // to TIMEOUT. As a result, done rises exactly TIMEOUT cycles after WAIT is entered.
    localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 2);

    state_t     state;
    logic [7:0] str_buf [32];
    logic [7:0] pat_buf [8];
    logic [5:0] slen_q;
    logic [3:0] plen_q;
    logic       head_q;
    logic       tail_q;
    logic [5:0] idx;
    logic [9:0] wait_cnt;
    logic [3:0] frame_len;
    logic       legal;

    assign frame_len = {3'b000, head_q} + plen_q + {3'b000, tail_q};
    assign legal     = (pat_len != 4'd0) && (pat_len <= 4'd8) && (str_len <= 6'd32);

    // Character at position pos of the pattern frame: optional '^', the body, then '$'.
    // Positions past the body can only be reached when the tail anchor is set.
    function automatic logic [7:0] frame_char(input logic [3:0] pos, input logic hd,
                                              input logic [3:0] pl);
        logic [3:0] body;
        body = pos - {3'b000, hd};
        if (hd && pos == 4'd0)
            return 8'h5E;
        else if (body < pl)
            return pat_buf[body[2:0]];
        else
            return 8'h24;
    endfunction

    // Host buffer writes are accepted only while idle. The buffers are deliberately not
    // reset, so their contents survive an aborted transaction.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            if (wr_sel)
                pat_buf[wr_addr[2:0]] <= wr_data;
            else
                str_buf[wr_addr] <= wr_data;
        end
    end

    // Transaction sequencer. Every output is loaded one edge ahead, so chardata and the
    // flags always show the character belonging to the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            chardata     <= 8'h00;
            isstring     <= 1'b0;
            ispattern    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_match <= 1'b0;
            result_index <= 5'd0;
            err          <= 1'b0;
            slen_q       <= 6'd0;
            plen_q       <= 4'd0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            idx          <= 6'd0;
            wait_cnt     <= 10'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        slen_q <= str_len;
                        plen_q <= pat_len;
                        head_q <= anchor_head;
                        tail_q <= anchor_tail;
                        busy   <= 1'b1;
                        if (!legal) begin
                            state        <= FIN;
                            err          <= 1'b1;
                            result_match <= 1'b0;
                            result_index <= 5'd0;
                        end else if (str_len != 6'd0) begin
                            state    <= SEND_STR;
                            chardata <= str_buf[0];
                            isstring <= 1'b1;
                            idx      <= 6'd1;
                        end else begin
                            state     <= SEND_PAT;
                            chardata  <= frame_char(4'd0, anchor_head, pat_len);
                            ispattern <= 1'b1;
                            idx       <= 6'd1;
                        end
                    end
                end
                SEND_STR: begin
                    if (idx == slen_q) begin
                        state     <= SEND_PAT;
                        isstring  <= 1'b0;
                        ispattern <= 1'b1;
                        chardata  <= frame_char(4'd0, head_q, plen_q);
                        idx       <= 6'd1;
                    end else begin
                        chardata <= str_buf[idx[4:0]];
                        idx      <= idx + 6'd1;
                    end
                end
                SEND_PAT: begin
                    if (idx == {2'b00, frame_len}) begin
                        state     <= GAP;
                        chardata  <= 8'h00;
                        ispattern <= 1'b0;
                        idx       <= 6'd0;
                    end else begin
                        chardata <= frame_char(idx[3:0], head_q, plen_q);
                        idx      <= idx + 6'd1;
                    end
                end
                GAP: begin
                    state    <= WAIT;
                    wait_cnt <= 10'd0;
                end
                WAIT: begin
                    if (valid) begin
                        result_match <= match;
                        result_index <= match_index;
                        err          <= 1'b0;
                        state        <= FIN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        result_match <= 1'b0;
                        result_index <= 5'd0;
                        err          <= 1'b1;
                        state        <= FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                FIN: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    wait_cnt <= 10'd0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sme_host_driver.md
SME_HOST_DRIVER -- requirements
Module: sme_host_driver

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 512, giving the maximum cycles to wait for valid after the pattern frame ends.
REQ-002 The block SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port wr_en, input, 1 bit: host buffer write strobe.
REQ-005 The block SHALL have port wr_sel, input, 1 bit: write target, 0 selects string buffer, 1 selects pattern buffer.
REQ-006 The block SHALL have port wr_addr, input, 5 bits: buffer address; only bits [2:0] are used for the pattern buffer.
REQ-007 The block SHALL have port wr_data, input, 8 bits: character to store.
REQ-008 The block SHALL have port start, input, 1 bit: request one match transaction.
REQ-009 The block SHALL have port str_len, input, 6 bits: string characters to send, 0..32; 0 means resend no string.
REQ-010 The block SHALL have port pat_len, input, 4 bits: pattern body characters, 1..8.
REQ-011 The block SHALL have port anchor_head, input, 1 bit: prepend '^' (8'h5E) to the pattern frame.
REQ-012 The block SHALL have port anchor_tail, input, 1 bit: append '$' (8'h24) to the pattern frame.
REQ-013 The block SHALL have port chardata, output, 8 bits: character to the matcher.
REQ-014 The block SHALL have port isstring, output, 1 bit: chardata is a string character.
REQ-015 The block SHALL have port ispattern, output, 1 bit: chardata is a pattern character.
REQ-016 The block SHALL have port valid, input, 1 bit: matcher result strobe.
REQ-017 The block SHALL have port match, input, 1 bit: matcher result.
REQ-018 The block SHALL have port match_index, input, 5 bits: matcher match position.
REQ-019 The block SHALL have port busy, output, 1 bit: a transaction is in progress.
REQ-020 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-021 The block SHALL have port result_match, output, 1 bit: captured match.
REQ-022 The block SHALL have port result_index, output, 5 bits: captured match_index.
REQ-023 The block SHALL have port err, output, 1 bit: last transaction ended by timeout or illegal lengths.

Function
REQ-024 Storage SHALL be a 32x8 string buffer and an 8x8 pattern buffer, written when wr_en=1 in IDLE; writes SHALL be ignored while busy=1.
REQ-025 The FSM SHALL have states IDLE, SEND_STR, SEND_PAT, GAP, WAIT, FIN.
REQ-026 In IDLE, start=1 SHALL latch str_len, pat_len and the anchors and set busy=1 on the next edge; start SHALL be ignored while busy=1.
REQ-027 If pat_len=0, pat_len>8 or str_len>32 at start, the FSM SHALL go directly to FIN with err=1 and SHALL assert neither isstring nor ispattern.
REQ-028 SEND_STR SHALL drive string[0..str_len-1] on chardata, one per cycle, with isstring=1; when str_len=0, SEND_STR SHALL be skipped.
REQ-029 SEND_PAT SHALL drive, with ispattern=1: 8'h5E if anchor_head, then pattern[0..pat_len-1], then 8'h24 if anchor_tail; this frame is 1..10 cycles.
REQ-030 SEND_PAT SHALL follow the last string character with no idle gap.
REQ-031 GAP SHALL drive exactly one cycle with isstring=0 and ispattern=0 (frame terminator), then enter WAIT.
REQ-032 chardata, isstring and ispattern SHALL be registered; outside SEND_STR/SEND_PAT, chardata SHALL be 8'h00 and both flags SHALL be 0.
REQ-033 isstring and ispattern SHALL never be 1 in the same cycle.
REQ-034 valid SHALL be sampled only in WAIT; valid in any other state SHALL be ignored.
REQ-035 On valid=1 in WAIT, the block SHALL capture result_match=match and result_index=match_index, set err=0, and go to FIN.
REQ-036 A 10-bit wait counter SHALL clear on WAIT entry and increment each WAIT cycle; if it reaches TIMEOUT without valid, the block SHALL go to FIN with err=1, result_match=0 and result_index=0.
REQ-037 FIN SHALL last one cycle with done=1, busy SHALL drop to 0 on the same edge, and the FSM SHALL return to IDLE.
REQ-038 result_match, result_index and err SHALL hold their values until the next FIN.
REQ-039 Transaction latency SHALL be: start edge, str_len string cycles, pattern frame cycles, 1 GAP cycle, WAIT cycles, then a 1-cycle done.

Reset
REQ-040 On reset, the block SHALL enter IDLE with chardata=0, isstring=0, ispattern=0, busy=0, done=0, result_match=0, result_index=0, err=0, and all counters 0.
REQ-041 Buffer contents SHALL NOT be reset; reset mid-transaction SHALL abort with no done pulse.

Verification
REQ-042 The bench SHALL cover: string "ab cd", str_len=5, pattern "cd", no anchors -> 5 isstring cycles, 2 ispattern cycles, 1 idle; model returns valid, match=1, index=3 -> done, result_match=1, result_index=3, err=0.
REQ-043 The bench SHALL cover: anchor_head=1, anchor_tail=1, pattern "c." -> ispattern chars 5E,63,2E,24 in consecutive cycles.
REQ-044 The bench SHALL cover: str_len=0, pat_len=1 -> isstring never asserted, 1 ispattern cycle, then GAP.
REQ-045 The bench SHALL cover: model never asserts valid -> done exactly TIMEOUT cycles after WAIT entry with err=1 and result_match=0.
REQ-046 The bench SHALL cover: pat_len=0 at start -> done 2 cycles after start with err=1 and no flag activity.
REQ-047 The bench SHALL cover: reset during SEND_STR -> all outputs 0 next cycle, no done; a following start resends the retained buffer correctly.
